// File: rtl/cache_fill_if.sv
// ============================================================================
// Module      : cache_fill_if
// Description : Bundle of signals between the cache miss handler, the cache
//               tag-compare logic, the memory arbiter and the data/metadata
//               arrays.
//               master modport : the fill FSM (drives requests and array writes)
//               slave modport  : the surrounding cache / memory environment
//   Signals:
//     miss_detected     env -> fsm  cache miss this cycle
//     miss_address      env -> fsm  byte address of the missing access
//     fsm_busy          fsm -> env  fill in progress, stall the pipeline
//     memory_read       fsm -> env  read request this cycle
//     memory_address    fsm -> env  word-aligned byte address of the request
//     memory_data_valid env -> fsm  memory_data holds a returned word
//     memory_data       env -> fsm  returned word, in request order
//     write_data_array  fsm -> env  write cache_data into the data array
//     cache_word_offset fsm -> env  word index inside the block
//     cache_data        fsm -> env  word to write into the data array
//     write_tag_array   fsm -> env  one-cycle tag/valid write pulse
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cache_fill_if #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
);
    localparam int c_OFF_W  = $clog2(WORDS_PER_BLOCK);
    localparam int c_DATA_W = 16;

    logic                  miss_detected;
    logic [ADDR_WIDTH-1:0] miss_address;
    logic                  fsm_busy;
    logic                  memory_read;
    logic [ADDR_WIDTH-1:0] memory_address;
    logic                  memory_data_valid;
    logic [c_DATA_W-1:0]   memory_data;
    logic                  write_data_array;
    logic [c_OFF_W-1:0]    cache_word_offset;
    logic [c_DATA_W-1:0]   cache_data;
    logic                  write_tag_array;

    modport master (
        input  miss_detected,
        input  miss_address,
        input  memory_data_valid,
        input  memory_data,
        output fsm_busy,
        output memory_read,
        output memory_address,
        output write_data_array,
        output cache_word_offset,
        output cache_data,
        output write_tag_array
    );

    modport slave (
        output miss_detected,
        output miss_address,
        output memory_data_valid,
        output memory_data,
        input  fsm_busy,
        input  memory_read,
        input  memory_address,
        input  write_data_array,
        input  cache_word_offset,
        input  cache_data,
        input  write_tag_array
    );
endinterface

`default_nettype wire

// File: rtl/cache_fill_fsm.sv
// ============================================================================
// Module      : cache_fill_fsm
// Description : Miss handler for the 2-way cache. On a miss it issues one
//               read per cycle for every word of the 16-byte block, writes
//               each returned word into the data array as it arrives, then
//               pulses a tag/valid write into the metadata array.
//               States: IDLE -> FILL -> TAG -> IDLE.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset, aborts any fill in progress
//     bus  : cache_fill_if.master (miss input, memory request/response,
//            data-array and tag-array write controls)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    cache_fill_if.master  bus
);
    localparam int c_CNT_W    = $clog2(WORDS_PER_BLOCK + 1);
    localparam int c_OFF_W    = $clog2(WORDS_PER_BLOCK);
    localparam int c_BLK_BITS = 4;

    localparam logic [c_CNT_W-1:0]    c_WORDS      = c_CNT_W'(WORDS_PER_BLOCK);
    localparam logic [c_CNT_W-1:0]    c_LAST       = c_CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_WIDTH-1:0] c_BLOCK_MASK =
        {{(ADDR_WIDTH-c_BLK_BITS){1'b1}}, {c_BLK_BITS{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_TAG  = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_req_cnt;
    logic [c_CNT_W-1:0]    r_rsp_cnt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_busy;
    logic                  r_mem_read;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_tag_wr;

    logic                  w_rsp_accept;
    logic [c_CNT_W-1:0]    w_req_cnt_nxt;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [ADDR_WIDTH-1:0] w_miss_base;

    // Responses only count while filling and while words are still owed;
    // anything else (late data after an abort, extras) is dropped.
    assign w_rsp_accept  = (r_state == ST_FILL) && bus.memory_data_valid &&
                           (r_rsp_cnt < c_WORDS);
    assign w_req_cnt_nxt = r_req_cnt + c_CNT_W'(1);
    // Word index -> byte offset is a shift by one; the block base is
    // 16-byte aligned so this addition never carries out of the block.
    assign w_next_addr   = r_base +
                           {{(ADDR_WIDTH-c_CNT_W-1){1'b0}}, w_req_cnt_nxt, 1'b0};
    assign w_miss_base   = bus.miss_address & c_BLOCK_MASK;

    // The request-side outputs are registered one cycle ahead: the value
    // loaded on each edge is what the next cycle's request must be.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req_cnt  <= '0;
            r_rsp_cnt  <= '0;
            r_base     <= '0;
            r_busy     <= 1'b0;
            r_mem_read <= 1'b0;
            r_mem_addr <= '0;
            r_tag_wr   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_busy     <= 1'b0;
                    r_mem_read <= 1'b0;
                    r_mem_addr <= '0;
                    r_tag_wr   <= 1'b0;
                    if (bus.miss_detected) begin
                        r_state    <= ST_FILL;
                        r_base     <= w_miss_base;
                        r_req_cnt  <= '0;
                        r_rsp_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_mem_read <= 1'b1;
                        r_mem_addr <= w_miss_base;
                    end
                end

                ST_FILL: begin
                    if (r_mem_read) begin
                        r_req_cnt <= w_req_cnt_nxt;
                        if (w_req_cnt_nxt < c_WORDS) begin
                            r_mem_addr <= w_next_addr;
                        end else begin
                            r_mem_read <= 1'b0;
                            r_mem_addr <= '0;
                        end
                    end
                    if (w_rsp_accept) begin
                        r_rsp_cnt <= r_rsp_cnt + c_CNT_W'(1);
                        if (r_rsp_cnt == c_LAST) begin
                            // Last word in: no further requests may leak
                            // into the TAG cycle.
                            r_state    <= ST_TAG;
                            r_tag_wr   <= 1'b1;
                            r_mem_read <= 1'b0;
                            r_mem_addr <= '0;
                        end
                    end
                end

                ST_TAG: begin
                    r_state    <= ST_IDLE;
                    r_tag_wr   <= 1'b0;
                    r_busy     <= 1'b0;
                    r_mem_read <= 1'b0;
                    r_mem_addr <= '0;
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_mem_read <= 1'b0;
                    r_mem_addr <= '0;
                    r_tag_wr   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fsm_busy          = r_busy;
    assign bus.memory_read       = r_mem_read;
    assign bus.memory_address    = r_mem_addr;
    assign bus.write_tag_array   = r_tag_wr;
    // Data-array write follows the response in the same cycle.
    assign bus.write_data_array  = w_rsp_accept;
    assign bus.cache_word_offset = r_rsp_cnt[c_OFF_W-1:0];
    assign bus.cache_data        = w_rsp_accept ? bus.memory_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
// ============================================================================
// Module      : tb_cache_fill_fsm
// Description : Self-checking bench for cache_fill_fsm. A pipelined memory
//               model answers each request three cycles later (optionally
//               with random extra stalls); observed requests and array
//               writes are compared against the block layout expected from
//               the miss address and the data the memory model returned.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_fill_fsm;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_fill_if #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(8)) bus ();

    cache_fill_fsm #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Observation log of one fill, cycle 0 = first cycle after the miss.
    logic [15:0] q_req_addr[$];
    int          q_req_cyc[$];
    logic [2:0]  q_wr_off[$];
    logic [15:0] q_wr_data[$];
    int          q_wr_cyc[$];
    logic [15:0] q_sent[$];
    int          pend_ready[$];
    int          tag_pulses, tag_cyc, tag_wr_seen, busy_cycles, overlap, timed_out;

    task automatic clear_log();
        q_req_addr.delete(); q_req_cyc.delete();
        q_wr_off.delete();   q_wr_data.delete(); q_wr_cyc.delete();
        q_sent.delete();     pend_ready.delete();
        tag_pulses = 0; tag_cyc = -1; tag_wr_seen = -1;
        busy_cycles = 0; overlap = 0; timed_out = 0;
    endtask

    // Issue a miss and act as memory until the FSM goes idle again (or until
    // abort_writes data words have been written, when nonzero).
    task automatic run_fill(input logic [15:0] addr, input bit stall,
                            input bit extra, input int abort_writes);
        int cyc;
        bit seen_busy;
        bit done;
        clear_log();
        @(posedge clk); #1;
        bus.miss_detected     = 1'b1;
        bus.miss_address      = addr;
        bus.memory_data_valid = 1'b0;
        @(negedge clk);
        cyc = 0; seen_busy = 0; done = 0;
        while (!done) begin
            @(posedge clk); #1;
            bus.miss_detected     = 1'b0;
            bus.memory_data_valid = 1'b0;
            if (pend_ready.size() > 0 && pend_ready[0] <= cyc &&
                (!stall || $urandom_range(0, 2) != 0)) begin
                void'(pend_ready.pop_front());
                bus.memory_data_valid = 1'b1;
                bus.memory_data       = 16'($urandom);
                q_sent.push_back(bus.memory_data);
            end else if (extra && pend_ready.size() == 0 && q_sent.size() >= 8) begin
                bus.memory_data_valid = 1'b1;
                bus.memory_data       = 16'($urandom);
            end
            @(negedge clk);
            if (bus.memory_read) begin
                q_req_addr.push_back(bus.memory_address);
                q_req_cyc.push_back(cyc);
                pend_ready.push_back(cyc + 3);
            end
            if (bus.write_data_array) begin
                q_wr_off.push_back(bus.cache_word_offset);
                q_wr_data.push_back(bus.cache_data);
                q_wr_cyc.push_back(cyc);
            end
            if (bus.write_tag_array) begin
                tag_pulses++;
                tag_cyc     = cyc;
                tag_wr_seen = q_wr_off.size();
            end
            if (bus.write_data_array && bus.write_tag_array) overlap++;
            if (bus.fsm_busy) begin
                busy_cycles++;
                seen_busy = 1;
            end else if (seen_busy) begin
                done = 1;
            end
            if (abort_writes > 0 && q_wr_off.size() >= abort_writes) done = 1;
            cyc++;
            if (cyc > 300) begin
                timed_out = 1;
                done      = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.fsm_busy, bus.memory_read, bus.memory_address, bus.write_data_array,
             bus.cache_word_offset, bus.cache_data, bus.write_tag_array} !== 39'd0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%0b rd=%0b addr=%h wr=%0b off=%0d data=%h tag=%0b, all must be 0",
                     bus.fsm_busy, bus.memory_read, bus.memory_address, bus.write_data_array,
                     bus.cache_word_offset, bus.cache_data, bus.write_tag_array);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic_fill();
        logic [15:0] base;
        base = 16'h1A37 & 16'hFFF0;
        run_fill(16'h1A37, 1'b0, 1'b0, 0);
        total++;
        if (timed_out !== 0) begin bad++; $display("FAIL basic_timeout: fill did not complete"); end
        total++;
        if (q_req_addr.size() !== 8) begin bad++; $display("FAIL basic_req_count: got %0d want 8", q_req_addr.size()); end
        for (int i = 0; i < q_req_addr.size() && i < 8; i++) begin
            total++;
            if (q_req_addr[i] !== base + 16'(2 * i) || q_req_cyc[i] !== i) begin
                bad++;
                $display("FAIL basic_req%0d: addr=%h cyc=%0d want addr=%h cyc=%0d",
                         i, q_req_addr[i], q_req_cyc[i], base + 16'(2 * i), i);
            end
        end
        total++;
        if (q_wr_off.size() !== 8) begin bad++; $display("FAIL basic_wr_count: got %0d want 8", q_wr_off.size()); end
        for (int i = 0; i < q_wr_off.size() && i < 8; i++) begin
            total++;
            if (q_wr_off[i] !== 3'(i) || q_wr_data[i] !== q_sent[i]) begin
                bad++;
                $display("FAIL basic_wr%0d: off=%0d data=%h want off=%0d data=%h",
                         i, q_wr_off[i], q_wr_data[i], i, q_sent[i]);
            end
        end
        total++;
        if (tag_pulses !== 1 || tag_wr_seen !== 8) begin
            bad++; $display("FAIL basic_tag: pulses=%0d words_before=%0d want 1 and 8", tag_pulses, tag_wr_seen);
        end
        total++;
        if (busy_cycles !== 12) begin bad++; $display("FAIL basic_busy: got %0d cycles want 12", busy_cycles); end
        total++;
        if (overlap !== 0) begin bad++; $display("FAIL basic_overlap: %0d cycles with both writes, want 0", overlap); end
    endtask

    task automatic test_top_wrap();
        run_fill(16'hFFFF, 1'b0, 1'b0, 0);
        total++;
        if (q_req_addr.size() !== 8) begin
            bad++; $display("FAIL wrap_req_count: got %0d want 8", q_req_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (q_req_addr[i] !== 16'hFFF0 + 16'(2 * i)) begin
                    bad++; $display("FAIL wrap_req%0d: addr=%h want %h", i, q_req_addr[i], 16'hFFF0 + 16'(2 * i));
                end
            end
            total++;
            if (q_req_addr[7] !== 16'hFFFE) begin bad++; $display("FAIL wrap_last: addr=%h want fffe", q_req_addr[7]); end
        end
    endtask

    task automatic test_random_stalls();
        for (int n = 0; n < 4; n++) begin
            logic [15:0] addr;
            addr = 16'($urandom);
            run_fill(addr, 1'b1, 1'b0, 0);
            total++;
            if (timed_out !== 0 || q_wr_off.size() !== 8 || q_req_addr.size() !== 8) begin
                bad++;
                $display("FAIL stall%0d_counts: timeout=%0d writes=%0d reqs=%0d want 0/8/8",
                         n, timed_out, q_wr_off.size(), q_req_addr.size());
            end else begin
                for (int i = 0; i < 8; i++) begin
                    total++;
                    if (q_wr_off[i] !== 3'(i) || q_wr_data[i] !== q_sent[i] ||
                        q_req_addr[i] !== (addr & 16'hFFF0) + 16'(2 * i) || q_req_cyc[i] !== i) begin
                        bad++;
                        $display("FAIL stall%0d_word%0d: off=%0d data=%h req=%h@%0d want off=%0d data=%h req=%h@%0d",
                                 n, i, q_wr_off[i], q_wr_data[i], q_req_addr[i], q_req_cyc[i],
                                 i, q_sent[i], (addr & 16'hFFF0) + 16'(2 * i), i);
                    end
                end
                total++;
                if (tag_pulses !== 1 || tag_wr_seen !== 8 || tag_cyc !== q_wr_cyc[7] + 1 ||
                    busy_cycles !== tag_cyc + 1 || overlap !== 0) begin
                    bad++;
                    $display("FAIL stall%0d_tag: pulses=%0d words=%0d tag_cyc=%0d last_wr=%0d busy=%0d overlap=%0d",
                             n, tag_pulses, tag_wr_seen, tag_cyc, q_wr_cyc[7], busy_cycles, overlap);
                end
            end
        end
    endtask

    task automatic test_spurious();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.memory_data_valid = 1'b1;
            bus.memory_data       = 16'($urandom);
            @(negedge clk);
            total++;
            if (bus.write_data_array !== 1'b0 || bus.fsm_busy !== 1'b0 || bus.cache_data !== 16'h0) begin
                bad++;
                $display("FAIL idle_valid%0d: wr=%0b busy=%0b data=%h want 0/0/0",
                         i, bus.write_data_array, bus.fsm_busy, bus.cache_data);
            end
        end
        run_fill(16'h2468, 1'b0, 1'b1, 0);
        bus.memory_data_valid = 1'b0;
        total++;
        if (q_wr_off.size() !== 8 || tag_pulses !== 1) begin
            bad++;
            $display("FAIL extra_valid: writes=%0d tags=%0d want 8 and 1", q_wr_off.size(), tag_pulses);
        end
    endtask

    task automatic test_reset_mid_fill();
        run_fill(16'h1A37, 1'b0, 1'b0, 3);
        @(posedge clk); #1;
        rst                   = 1'b1;
        bus.memory_data_valid = 1'b1;
        bus.memory_data       = 16'($urandom);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.fsm_busy, bus.memory_read, bus.memory_address, bus.write_data_array,
             bus.cache_word_offset, bus.cache_data, bus.write_tag_array} !== 39'd0) begin
            bad++;
            $display("FAIL midrst_outputs: busy=%0b rd=%0b addr=%h wr=%0b off=%0d data=%h tag=%0b, all must be 0",
                     bus.fsm_busy, bus.memory_read, bus.memory_address, bus.write_data_array,
                     bus.cache_word_offset, bus.cache_data, bus.write_tag_array);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.memory_data = 16'($urandom);
            @(negedge clk);
            total++;
            if (bus.write_data_array !== 1'b0 || bus.fsm_busy !== 1'b0) begin
                bad++; $display("FAIL midrst_late%0d: wr=%0b busy=%0b want 0/0", i, bus.write_data_array, bus.fsm_busy);
            end
        end
        bus.memory_data_valid = 1'b0;
        run_fill(16'h0040, 1'b0, 1'b0, 0);
        total++;
        if (q_req_addr.size() !== 8 || q_wr_off.size() !== 8) begin
            bad++; $display("FAIL midrst_refill_count: reqs=%0d writes=%0d want 8/8", q_req_addr.size(), q_wr_off.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (q_req_addr[i] !== 16'h0040 + 16'(2 * i) || q_wr_off[i] !== 3'(i) || q_wr_data[i] !== q_sent[i]) begin
                    bad++;
                    $display("FAIL midrst_refill%0d: req=%h off=%0d data=%h want req=%h off=%0d data=%h",
                             i, q_req_addr[i], q_wr_off[i], q_wr_data[i], 16'h0040 + 16'(2 * i), i, q_sent[i]);
                end
            end
        end
    endtask

    initial begin
        rst                   = 1'b1;
        bus.miss_detected     = 1'b0;
        bus.miss_address      = 16'h0;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'h0;
        test_reset();
        test_basic_fill();
        test_top_wrap();
        test_random_stalls();
        test_spurious();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
